// File: rtl/ps2_key_mapper.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_mapper
// Description : PS/2 scancode stream to per-key held levels, press pulses and
//               delayed auto-repeat (DAS/ARR) pulses.
// Revision    : 1.0
// ============================================================================
module ps2_key_mapper #(
    parameter int                      NUM_KEYS    = 8,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES   = {8'h1B, 8'h23, 8'h1C, 8'h29,
                                                      8'h75, 8'h72, 8'h74, 8'h6B},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT     = 8'b0000_1111,
    parameter logic [NUM_KEYS-1:0]     REPEAT_MASK = 8'b1110_0111,
    parameter int                      DAS_CYCLES  = 17_000_000,
    parameter int                      ARR_CYCLES  = 5_000_000,
    parameter int                      CNT_W       = $clog2(DAS_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                rx_error,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                any_held
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // The pulse is registered, so it is armed one count early to land exactly
    // DAS cycles after the press pulse; re-arming then yields an ARR period.
    localparam logic [CNT_W-1:0] c_das_m1 = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rearm  = CNT_W'(DAS_CYCLES - ARR_CYCLES);

    state_t              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic                ev_make, ev_brk, ev_ext;
    logic [NUM_KEYS-1:0] hit;

    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;
    logic                any_q, any_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_make = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else begin
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_brk  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (flush || rx_error) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
            ev_make = 1'b0;
            ev_brk  = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_hit
        assign hit[g] = (rx_data == KEY_CODES[g*8 +: 8]) && (ev_ext == KEY_EXT[g]);
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            held_d[i]  = held_q[i];
            pulse_d[i] = 1'b0;
            cnt_d[i]   = cnt_q[i];
            if (flush) begin
                held_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end else if (ev_make && hit[i] && !held_q[i]) begin
                held_d[i]  = 1'b1;
                pulse_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end else if (ev_brk && hit[i]) begin
                held_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end else if (REPEAT_MASK[i] && held_q[i]) begin
                if (cnt_q[i] == c_das_m1) begin
                    pulse_d[i] = 1'b1;
                    cnt_d[i]   = c_rearm;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        any_d = |held_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            held_q  <= held_d;
            pulse_q <= pulse_d;
            any_q   <= any_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_held  = held_q;
    assign key_pulse = pulse_q;
    assign any_held  = any_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_mapper
// Description : Self-checking bench for ps2_key_mapper against a timing model.
// Revision    : 1.0
// ============================================================================
module tb_ps2_key_mapper;

    localparam int NK  = 8;
    localparam int DAS = 10;
    localparam int ARR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_error;
    logic          flush;
    logic [NK-1:0] key_held;
    logic [NK-1:0] key_pulse;
    logic          any_held;

    ps2_key_mapper #(
        .NUM_KEYS    (NK),
        .KEY_CODES   ({8'h1B, 8'h23, 8'h1C, 8'h29, 8'h75, 8'h72, 8'h74, 8'h6B}),
        .KEY_EXT     (8'b0000_1111),
        .REPEAT_MASK (8'b1110_0111),
        .DAS_CYCLES  (DAS),
        .ARR_CYCLES  (ARR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .flush     (flush),
        .key_held  (key_held),
        .key_pulse (key_pulse),
        .any_held  (any_held)
    );

    always #5 clk = ~clk;

    // Key table: Left, Right, Down, Up, Space, A, D, S
    logic [7:0] codes [NK] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h1C, 8'h23, 8'h1B};
    bit         extk  [NK] = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit         rmask [NK] = '{1, 1, 1, 0, 0, 1, 1, 1};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: prefix flags plus, per key, held flag and the cycle of its press pulse.
    bit m_ext, m_brk;
    int m_pause;
    bit m_held  [NK];
    int m_press [NK];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_event(input bit make, input logic [7:0] code, input bit ext);
        for (int k = 0; k < NK; k++) begin
            if (code == codes[k] && ext == extk[k]) begin
                if (make && !m_held[k]) begin
                    m_held[k]  = 1;
                    m_press[k] = cyc;
                end else if (!make) begin
                    m_held[k] = 0;
                end
            end
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic err, input logic fl);
        cyc++;
        if (rst || fl) begin
            m_ext = 0; m_brk = 0; m_pause = 0;
            for (int k = 0; k < NK; k++) m_held[k] = 0;
        end else if (err) begin
            m_ext = 0; m_brk = 0; m_pause = 0;
        end else if (v) begin
            if (m_pause > 0) begin
                m_pause--;
            end else if (m_brk) begin
                model_event(0, d, m_ext);
                m_brk = 0; m_ext = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hE1 && !m_ext) begin
                m_pause = 7;
            end else begin
                model_event(1, d, m_ext);
                m_ext = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_held();
        logic [31:0] r = '0;
        for (int k = 0; k < NK; k++) r[k] = m_held[k];
        return r;
    endfunction

    function automatic logic [31:0] exp_pulse();
        logic [31:0] r = '0;
        for (int k = 0; k < NK; k++) begin
            int dt = cyc - m_press[k];
            if (m_held[k])
                r[k] = (dt == 0) || (rmask[k] && dt >= DAS && ((dt - DAS) % ARR) == 0);
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic err, input logic fl);
        rx_valid = v; rx_data = d; rx_error = err; flush = fl;
        @(posedge clk);
        model_edge(v, d, err, fl);
        #1;
        rx_valid = 0; rx_error = 0; flush = 0;
        check_eq("key_held", 32'(key_held), exp_held());
        check_eq("key_pulse", 32'(key_pulse), exp_pulse());
        check_eq("any_held", 32'(any_held), 32'(exp_held() != 0));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1; rx_data = 0; rx_valid = 0; rx_error = 0; flush = 0;
        for (int k = 0; k < NK; k++) begin m_held[k] = 0; m_press[k] = 0; end
        idle(2);
        rst = 0;
        idle(2);

        // Extended Left press, hold through several repeats, then release
        send(8'hE0); send(8'h6B); idle(20);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(5);
        // Unprefixed 6B is unmapped; Space has no repeat
        send(8'h6B); idle(3);
        send(8'h29); idle(50); send(8'hF0); send(8'h29); idle(3);
        // Typematic re-make must not restart repeat timing
        send(8'h1C); idle(4); send(8'h1C); idle(15); send(8'hF0); send(8'h1C); idle(3);
        // Pause sequence swallows seven bytes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C); idle(3); send(8'hF0); send(8'h1C); idle(2);
        // Error drops the E0 prefix
        send(8'hE0); step(1'b0, 8'h00, 1'b1, 1'b0); send(8'h6B); idle(2);
        // Flush with a coincident byte, then a fresh make
        send(8'hE0); send(8'h6B); send(8'h29); idle(2);
        step(1'b1, 8'hF0, 1'b0, 1'b1); idle(1);
        send(8'h29); idle(3); send(8'hF0); send(8'h29); idle(2);

        for (int n = 0; n < 2500; n++) begin
            int r = $urandom_range(0, 99);
            logic [7:0] b;
            if (r < 35)      b = codes[$urandom_range(0, NK-1)];
            else if (r < 50) b = 8'hE0;
            else if (r < 62) b = 8'hF0;
            else if (r < 64) b = 8'hE1;
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 199);
            if (r < 2)      step(1'b1, b, 1'b0, 1'b1);
            else if (r < 6) step(1'($urandom_range(0, 1)), b, 1'b1, 1'b0);
            else            step(1'b1, b, 1'b0, 1'b0);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(0, 40));
            else                           idle($urandom_range(0, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
